// File: rtl/conv_host_driver_if.sv
// Host-side request/response channel of the convolver front-end.
// The slave modport is the driver; the master modport is the host.
interface conv_host_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_a;
  logic [5:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/conv_host_driver.sv
// Initiator-side driver for the bitwise convolver: latches an operand pair,
// runs the convolver out of reset for LATENCY cycles, then returns its result.
//
// state | meaning
// IDLE  | convolver held in reset, waiting for a request
// RUN   | convolver out of reset, counting down LATENCY cycles
// RESP  | result captured, waiting for the host to take it
module conv_host_driver #(
  parameter int unsigned LATENCY = 9
) (
  input  logic                clock,
  input  logic                reset_n,
  conv_host_driver_if.slave   host,
  output logic [11:0]         conv_in,
  output logic                conv_reset,
  input  logic [3:0]          conv_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [11:0] conv_in_q;
  logic [3:0]  rsp_data_q;
  logic        rsp_valid_q;

  logic        accept;
  logic        capture;
  logic        rsp_fire;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (host.req_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && host.rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter holds LATENCY-1 on entry to RUN, so RUN spans exactly LATENCY cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
    end else if (state_q == RUN && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conv_in_q <= 12'h000;
    end else if (accept) begin
      conv_in_q <= {host.req_b, host.req_a};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_q  <= 4'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (capture) begin
        rsp_data_q  <= conv_out;
        rsp_valid_q <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Handshake and convolver-reset outputs decode straight from the state register.
  assign host.req_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign conv_reset     = (state_q != RUN);
  assign conv_in        = conv_in_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_conv_host_driver.sv
// Bench for conv_host_driver: a LATENCY=9 and a LATENCY=1 instance, each
// driving a counting convolver stub, checked against a job-level model.
module tb_conv_host_driver;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  conv_host_driver_if hif_a ();
  conv_host_driver_if hif_b ();

  logic [11:0] conv_in_a, conv_in_b;
  logic        conv_reset_a, conv_reset_b;
  logic [3:0]  conv_out_a, conv_out_b;
  logic        busy_a, busy_b;

  // Convolver stub: counts cycles spent out of reset; optionally adds operand A's low nibble.
  logic [3:0]  stub_cnt_a = 4'd0;
  logic [3:0]  stub_cnt_b = 4'd0;
  logic        stub_mix = 1'b0;

  always @(posedge clock) stub_cnt_a <= conv_reset_a ? 4'd0 : stub_cnt_a + 4'd1;
  always @(posedge clock) stub_cnt_b <= conv_reset_b ? 4'd0 : stub_cnt_b + 4'd1;
  assign conv_out_a = stub_cnt_a + (stub_mix ? conv_in_a[3:0] : 4'd0);
  assign conv_out_b = stub_cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  conv_host_driver #(.LATENCY(9)) u_dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .host       (hif_a),
    .conv_in    (conv_in_a),
    .conv_reset (conv_reset_a),
    .conv_out   (conv_out_a),
    .busy       (busy_a)
  );

  conv_host_driver #(.LATENCY(1)) u_dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .host       (hif_b),
    .conv_in    (conv_in_b),
    .conv_reset (conv_reset_b),
    .conv_out   (conv_out_b),
    .busy       (busy_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (hif_a.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_hold_ready got %b exp 1", hif_a.req_ready); end
    n_cmp++; if (conv_reset_a !== 1'b1) begin n_err++; $display("FAIL rst_hold_conv_reset got %b exp 1", conv_reset_a); end
    @(posedge clock);
    #1 reset_n = 1'b1;
    step();
    n_cmp++; if (hif_a.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", hif_a.req_ready); end
    n_cmp++; if (hif_a.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", hif_a.rsp_valid); end
    n_cmp++; if (hif_a.rsp_data !== 4'd0) begin n_err++; $display("FAIL rst_rsp_data got %h exp 0", hif_a.rsp_data); end
    n_cmp++; if (conv_reset_a !== 1'b1) begin n_err++; $display("FAIL rst_conv_reset got %b exp 1", conv_reset_a); end
    n_cmp++; if (conv_in_a !== 12'h000) begin n_err++; $display("FAIL rst_conv_in got %h exp 000", conv_in_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy_a); end
  endtask

  task automatic test_single_job();
    int edges;
    int low_cnt;
    int bad_in;
    hif_a.req_a = 6'b101101;
    hif_a.req_b = 6'b110011;
    hif_a.req_valid = 1'b1;
    step();
    hif_a.req_valid = 1'b0;
    edges = 1; low_cnt = 0; bad_in = 0;
    while (hif_a.rsp_valid !== 1'b1 && edges < 30) begin
      if (conv_reset_a === 1'b0) low_cnt++;
      if (conv_in_a !== 12'hCED) bad_in++;
      step();
      edges++;
    end
    n_cmp++; if (edges !== 10) begin n_err++; $display("FAIL single_latency got %0d edges exp 10", edges); end
    n_cmp++; if (low_cnt !== 9) begin n_err++; $display("FAIL single_run_len got %0d exp 9", low_cnt); end
    n_cmp++; if (bad_in !== 0) begin n_err++; $display("FAIL single_conv_in unstable in %0d cycles exp 0", bad_in); end
    n_cmp++; if (hif_a.rsp_data !== 4'd8) begin n_err++; $display("FAIL single_rsp_data got %0d exp 8", hif_a.rsp_data); end
    n_cmp++; if (conv_reset_a !== 1'b1) begin n_err++; $display("FAIL single_resp_conv_reset got %b exp 1", conv_reset_a); end
  endtask

  // Entered with the single job's result pending in RESP.
  task automatic test_backpressure();
    int bad;
    int edges;
    hif_a.rsp_ready = 1'b0;
    hif_a.req_valid = 1'b1;
    hif_a.req_a = 6'h15;
    hif_a.req_b = 6'h0A;
    bad = 0;
    repeat (5) begin
      if (hif_a.rsp_valid !== 1'b1 || hif_a.rsp_data !== 4'd8 || hif_a.req_ready !== 1'b0 || conv_in_a !== 12'hCED) bad++;
      step();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold bad cycles got %0d exp 0", bad); end
    hif_a.rsp_ready = 1'b1;
    step();
    hif_a.rsp_ready = 1'b0;
    n_cmp++; if (hif_a.req_ready !== 1'b1 || hif_a.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle ready/valid got %b/%b exp 1/0", hif_a.req_ready, hif_a.rsp_valid); end
    n_cmp++; if (conv_in_a !== 12'hCED || hif_a.rsp_data !== 4'd8) begin n_err++; $display("FAIL bp_idle_keep conv_in/data got %h/%0d exp CED/8", conv_in_a, hif_a.rsp_data); end
    step();
    hif_a.req_valid = 1'b0;
    n_cmp++; if (conv_in_a !== 12'h295 || busy_a !== 1'b1) begin n_err++; $display("FAIL bp_accept conv_in/busy got %h/%b exp 295/1", conv_in_a, busy_a); end
    edges = 1;
    while (hif_a.rsp_valid !== 1'b1 && edges < 30) begin step(); edges++; end
    n_cmp++; if (edges !== 10 || hif_a.rsp_data !== 4'd8) begin n_err++; $display("FAIL bp_second_job edges/data got %0d/%0d exp 10/8", edges, hif_a.rsp_data); end
    hif_a.rsp_ready = 1'b1;
    step();
    hif_a.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int acc_n;
    int acc_cyc [2];
    logic [11:0] pair [2];
    pair[0] = {6'h3F, 6'h3F};
    pair[1] = {6'h2A, 6'h00};
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    hif_a.rsp_ready = 1'b1;
    hif_a.req_valid = 1'b1;
    {hif_a.req_b, hif_a.req_a} = pair[0];
    cyc = 0; acc_n = 0;
    while (acc_n < 2 && cyc < 40) begin
      if (hif_a.req_ready === 1'b1) begin
        if (acc_n == 1) begin
          n_cmp++; if (conv_in_a !== pair[0]) begin n_err++; $display("FAIL b2b_hold conv_in got %h exp %h", conv_in_a, pair[0]); end
        end
        acc_cyc[acc_n] = cyc;
        step();
        n_cmp++; if (conv_in_a !== pair[acc_n]) begin n_err++; $display("FAIL b2b_conv_in job %0d got %h exp %h", acc_n, conv_in_a, pair[acc_n]); end
        acc_n++;
        if (acc_n < 2) {hif_a.req_b, hif_a.req_a} = pair[acc_n];
        else hif_a.req_valid = 1'b0;
      end else begin
        step();
      end
      cyc++;
    end
    n_cmp++; if (acc_n !== 2 || acc_cyc[1] - acc_cyc[0] !== 11) begin n_err++; $display("FAIL b2b_spacing got %0d cycles (%0d accepts) exp 11", acc_cyc[1] - acc_cyc[0], acc_n); end
    cyc = 0;
    while (busy_a !== 1'b0 && cyc < 30) begin step(); cyc++; end
    hif_a.rsp_ready = 1'b0;
    n_cmp++; if (busy_a !== 1'b0 || hif_a.rsp_data !== 4'd8 || conv_in_a !== pair[1]) begin n_err++; $display("FAIL b2b_drain busy/data/conv_in got %b/%0d/%h exp 0/8/%h", busy_a, hif_a.rsp_data, conv_in_a, pair[1]); end
  endtask

  task automatic test_min_latency();
    int edges;
    hif_b.req_a = 6'h21;
    hif_b.req_b = 6'h12;
    hif_b.req_valid = 1'b1;
    hif_b.rsp_ready = 1'b0;
    step();
    hif_b.req_valid = 1'b0;
    n_cmp++; if (conv_reset_b !== 1'b0 || busy_b !== 1'b1 || conv_in_b !== 12'h4A1) begin n_err++; $display("FAIL min_run conv_reset/busy/conv_in got %b/%b/%h exp 0/1/4A1", conv_reset_b, busy_b, conv_in_b); end
    edges = 1;
    while (hif_b.rsp_valid !== 1'b1 && edges < 10) begin step(); edges++; end
    n_cmp++; if (edges !== 2) begin n_err++; $display("FAIL min_latency got %0d edges exp 2", edges); end
    n_cmp++; if (hif_b.rsp_data !== 4'd0 || conv_reset_b !== 1'b1) begin n_err++; $display("FAIL min_result data/conv_reset got %0d/%b exp 0/1", hif_b.rsp_data, conv_reset_b); end
    hif_b.rsp_ready = 1'b1;
    step();
    hif_b.rsp_ready = 1'b0;
    n_cmp++; if (hif_b.req_ready !== 1'b1 || hif_b.rsp_valid !== 1'b0) begin n_err++; $display("FAIL min_done ready/valid got %b/%b exp 1/0", hif_b.req_ready, hif_b.rsp_valid); end
  endtask

  task automatic test_random();
    logic [5:0] a, b;
    logic [3:0] exp_d;
    int edges, bad_in, bad_hold, hold;
    stub_mix = 1'b1;
    for (int j = 0; j < 20; j++) begin
      repeat ($urandom_range(0, 3)) step();
      a = 6'($urandom);
      b = 6'($urandom);
      hif_a.req_a = a;
      hif_a.req_b = b;
      hif_a.req_valid = 1'b1;
      n_cmp++; if (hif_a.req_ready !== 1'b1) begin n_err++; $display("FAIL rnd_ready job %0d got %b exp 1", j, hif_a.req_ready); end
      step();
      edges = 1; bad_in = 0;
      while (hif_a.rsp_valid !== 1'b1 && edges < 40) begin
        if (conv_in_a !== {b, a} || conv_reset_a !== 1'b0) bad_in++;
        hif_a.req_valid = 1'($urandom);
        hif_a.req_a = 6'($urandom);
        hif_a.req_b = 6'($urandom);
        step();
        edges++;
      end
      exp_d = 4'(a[3:0] + 4'd8);
      n_cmp++; if (edges !== 10) begin n_err++; $display("FAIL rnd_latency job %0d got %0d edges exp 10", j, edges); end
      n_cmp++; if (bad_in !== 0) begin n_err++; $display("FAIL rnd_run job %0d bad cycles got %0d exp 0", j, bad_in); end
      n_cmp++; if (hif_a.rsp_data !== exp_d) begin n_err++; $display("FAIL rnd_data job %0d got %h exp %h", j, hif_a.rsp_data, exp_d); end
      hold = $urandom_range(0, 3); bad_hold = 0;
      repeat (hold) begin
        if (hif_a.rsp_valid !== 1'b1 || hif_a.rsp_data !== exp_d || hif_a.req_ready !== 1'b0 || conv_in_a !== {b, a}) bad_hold++;
        hif_a.req_a = 6'($urandom);
        step();
      end
      n_cmp++; if (bad_hold !== 0) begin n_err++; $display("FAIL rnd_hold job %0d bad cycles got %0d exp 0", j, bad_hold); end
      hif_a.rsp_ready = 1'b1;
      step();
      hif_a.rsp_ready = 1'b0;
      hif_a.req_valid = 1'b0;
      n_cmp++; if (hif_a.rsp_valid !== 1'b0 || hif_a.req_ready !== 1'b1 || hif_a.rsp_data !== exp_d) begin n_err++; $display("FAIL rnd_done job %0d valid/ready/data got %b/%b/%h exp 0/1/%h", j, hif_a.rsp_valid, hif_a.req_ready, hif_a.rsp_data, exp_d); end
    end
    stub_mix = 1'b0;
  endtask

  task automatic test_reset_during_run();
    int seen;
    hif_a.req_a = 6'h07;
    hif_a.req_b = 6'h38;
    hif_a.req_valid = 1'b1;
    step();
    hif_a.req_valid = 1'b0;
    repeat (3) step();
    n_cmp++; if (conv_reset_a !== 1'b0 || busy_a !== 1'b1) begin n_err++; $display("FAIL rdr_in_run conv_reset/busy got %b/%b exp 0/1", conv_reset_a, busy_a); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (conv_reset_a !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL rdr_async conv_reset/busy got %b/%b exp 1/0", conv_reset_a, busy_a); end
    n_cmp++; if (hif_a.rsp_valid !== 1'b0 || hif_a.rsp_data !== 4'd0 || conv_in_a !== 12'h000 || hif_a.req_ready !== 1'b1) begin n_err++; $display("FAIL rdr_clear valid/data/conv_in/ready got %b/%h/%h/%b exp 0/0/000/1", hif_a.rsp_valid, hif_a.rsp_data, conv_in_a, hif_a.req_ready); end
    step();
    step();
    reset_n = 1'b1;
    seen = 0;
    repeat (15) begin
      if (hif_a.rsp_valid !== 1'b0 || busy_a !== 1'b0) seen++;
      step();
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rdr_no_rsp cycles with activity got %0d exp 0", seen); end
  endtask

  initial begin
    hif_a.req_valid = 1'b0; hif_a.req_a = 6'h00; hif_a.req_b = 6'h00; hif_a.rsp_ready = 1'b0;
    hif_b.req_valid = 1'b0; hif_b.req_a = 6'h00; hif_b.req_b = 6'h00; hif_b.rsp_ready = 1'b0;
    test_reset();
    test_single_job();
    test_backpressure();
    test_back_to_back();
    test_min_latency();
    test_random();
    test_reset_during_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached after %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
